hdmi_vram_fb: RTL and testbench
===============================

HDMI_VRAM_FB -- requirements
Module: hdmi_vram_fb

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 13, word address width; depth = 2**ADDR_W words.
REQ-003 Derived constant NB = DATA_W/8, the byte-lane count.
REQ-004 Ports SHALL be:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  cpu_req  in  1  CPU access request
  cpu_we  in  1  1 = write, 0 = read
  cpu_be  in  NB  byte enables for a write
  cpu_addr  in  ADDR_W  CPU word address
  cpu_wdata  in  DATA_W  CPU write data
  cpu_ready  out  1  CPU request accepted this cycle
  cpu_rvalid  out  1  CPU read data valid
  cpu_rdata  out  DATA_W  CPU read data
  vid_en  in  1  video read request
  vid_addr  in  ADDR_W  video word address
  vid_rvalid  out  1  video read data valid
  vid_rdata  out  DATA_W  video read data
  fill_start  in  1  start a fill, single-cycle pulse
  fill_base  in  ADDR_W  first fill address
  fill_len  in  ADDR_W+1  number of words to fill
  fill_pattern  in  DATA_W  fill word
  fill_busy  out  1  fill engine active
  fill_done  out  1  fill complete, 1-cycle pulse

Function
REQ-005 Storage SHALL be a two-port RAM: port A is shared by the CPU and the fill engine and is read/write with byte enables; port B is video read-only.
REQ-006 cpu_ready SHALL be the combinational value !fill_busy; a transfer occurs when cpu_req && cpu_ready.
REQ-007 An accepted CPU write SHALL update exactly the byte lanes with cpu_be[i]=1 at that clock edge; cpu_be=0 SHALL leave the word unchanged.
REQ-008 An accepted CPU read SHALL assert cpu_rvalid for exactly one cycle on the following cycle, with cpu_rdata holding the word; cpu_rdata SHALL hold its value otherwise.
REQ-009 vid_en=1 SHALL produce vid_rvalid=1 and vid_rdata=mem[vid_addr] one cycle later; back-to-back requests SHALL give one word per cycle.
REQ-010 When port A writes and port B reads the same address in the same cycle, vid_rdata SHALL return the pre-write data.
REQ-011 The fill FSM SHALL have states IDLE, FILL and DONE.
REQ-012 In IDLE, fill_start SHALL latch base, len and pattern; len>0 SHALL go to FILL, and len=0 SHALL go directly to DONE with no writes.
REQ-013 In FILL, the engine SHALL write pattern to every byte lane, one word per cycle, for len consecutive cycles at base, base+1, and so on, wrapping modulo 2**ADDR_W; the last write SHALL go to DONE.
REQ-014 DONE SHALL last one cycle with fill_done=1, then go to IDLE.
REQ-015 fill_busy SHALL be 1 in FILL and DONE.
REQ-016 fill_start SHALL be ignored while fill_busy=1.
REQ-017 fill_len=2**ADDR_W SHALL fill the whole memory exactly once.
REQ-018 If fill_start and cpu_req arrive in the same IDLE cycle, the CPU access SHALL complete that cycle and the first fill write SHALL occur the next cycle.
REQ-019 Video reads SHALL never stall, including during a fill.

Reset
REQ-020 While rst_n=0 (asynchronous): FSM in IDLE; fill_busy, fill_done, cpu_rvalid and vid_rvalid = 0; cpu_rdata and vid_rdata = 0.
REQ-021 RAM contents SHALL NOT be reset and are undefined after power-up.
REQ-022 Reset during FILL SHALL abort the fill with no fill_done pulse; words already written SHALL keep their written value.

Structure
REQ-023 Package hdmi_vram_pkg SHALL hold the FSM state typedef and the default DATA_W/ADDR_W constants.
REQ-024 The RAM SHALL be a sub-module hdmi_vram_dpram (byte-enable port A, read-only port B, read-before-write), inferable as block RAM; the FSM and muxing live in the top.

Verification
REQ-025 CPU write 0xAABBCCDD to address 5 with be=4'b1111, then write 0x11223344 to address 5 with be=4'b0101, then read address 5 -> cpu_rdata=0xAA22CC44 one cycle after acceptance, cpu_rvalid high 1 cycle.
REQ-026 Fill base=0x1FFE, len=4, pattern=0x5A5A5A5A (ADDR_W=13) -> writes at 0x1FFE, 0x1FFF, 0x0000, 0x0001; fill_busy for 5 cycles; fill_done on the 5th.
REQ-027 Fill with len=0 -> fill_done one cycle after start, no memory change, and cpu_req stalled (cpu_ready=0) for exactly 1 cycle.
REQ-028 During a fill, CPU write request held -> not accepted until fill_busy falls; video reads of filled addresses continue every cycle and show the old value on a same-cycle collision.
REQ-029 Assert rst_n low mid-fill after 3 of 10 writes -> outputs zero immediately, no fill_done; after release, a new fill_start is accepted.

Source files
------------

// File: rtl/hdmi_vram_pkg.sv
// Shared types and default geometry for the HDMI video RAM framebuffer.
// The fill engine state type and the default word/address widths live here.
package hdmi_vram_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/hdmi_vram_dpram.sv
// Two-port framebuffer RAM: port A read/write with byte enables, port B read-only.
// Both ports are read-before-write, so a same-cycle collision returns the old word.
module hdmi_vram_dpram
    import hdmi_vram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    localparam int NB = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              aEn_i,
    input  logic              aWe_i,
    input  logic [NB-1:0]     aBe_i,
    input  logic [ADDR_W-1:0] aAddr_i,
    input  logic [DATA_W-1:0] aWdata_i,
    output logic [DATA_W-1:0] aRdata_o,
    input  logic              bEn_i,
    input  logic [ADDR_W-1:0] bAddr_i,
    output logic [DATA_W-1:0] bRdata_o
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] aRdata_q;
    logic [DATA_W-1:0] bRdata_q;

    // Array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (aEn_i && aWe_i) begin
            for (int i = 0; i < NB; i++) begin
                if (aBe_i[i]) begin
                    mem[aAddr_i][i*8 +: 8] <= aWdata_i[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aRdata_q <= '0;
        end else if (aEn_i && !aWe_i) begin
            aRdata_q <= mem[aAddr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bRdata_q <= '0;
        end else if (bEn_i) begin
            bRdata_q <= mem[bAddr_i];
        end
    end

    assign aRdata_o = aRdata_q;
    assign bRdata_o = bRdata_q;

endmodule

// File: rtl/hdmi_vram_fb.sv
// Framebuffer top: CPU and fill engine share RAM port A, video scanout owns port B.
// The fill engine takes priority over the CPU, which is stalled through cpu_ready.
module hdmi_vram_fb
    import hdmi_vram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    localparam int NB = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [NB-1:0]     cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_en,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_pattern,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fillAddr_q, fillAddr_d;
    logic [ADDR_W:0]   fillLeft_q, fillLeft_d;
    logic [DATA_W-1:0] fillPattern_q, fillPattern_d;
    logic              cpuRvalid_q;
    logic              vidRvalid_q;

    logic              cpuAccept;
    logic              aEn;
    logic              aWe;
    logic [NB-1:0]     aBe;
    logic [ADDR_W-1:0] aAddr;
    logic [DATA_W-1:0] aWdata;

    assign fill_busy = (state_q != IDLE);
    assign fill_done = (state_q == DONE);
    assign cpu_ready = !fill_busy;
    assign cpuAccept = cpu_req && cpu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fillAddr_q    <= '0;
            fillLeft_q    <= '0;
            fillPattern_q <= '0;
            cpuRvalid_q   <= 1'b0;
            vidRvalid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fillAddr_q    <= fillAddr_d;
            fillLeft_q    <= fillLeft_d;
            fillPattern_q <= fillPattern_d;
            cpuRvalid_q   <= cpuAccept && !cpu_we;
            vidRvalid_q   <= vid_en;
        end
    end

    // A start is only sampled in IDLE, so a pulse while busy is dropped.
    always_comb begin
        state_d       = state_q;
        fillAddr_d    = fillAddr_q;
        fillLeft_d    = fillLeft_q;
        fillPattern_d = fillPattern_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    fillAddr_d    = fill_base;
                    fillLeft_d    = fill_len;
                    fillPattern_d = fill_pattern;
                    state_d       = (fill_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                fillAddr_d = fillAddr_q + ADDR_ONE;
                fillLeft_d = fillLeft_q - LEN_ONE;
                if (fillLeft_q == LEN_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port A belongs to the fill engine in FILL, otherwise to an accepted CPU access.
    always_comb begin
        aEn    = 1'b0;
        aWe    = 1'b0;
        aBe    = '0;
        aAddr  = cpu_addr;
        aWdata = cpu_wdata;
        if (state_q == FILL) begin
            aEn    = 1'b1;
            aWe    = 1'b1;
            aBe    = '1;
            aAddr  = fillAddr_q;
            aWdata = fillPattern_q;
        end else if (cpuAccept) begin
            aEn = 1'b1;
            aWe = cpu_we;
            aBe = cpu_be;
        end
    end

    hdmi_vram_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dpram (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .aEn_i    (aEn),
        .aWe_i    (aWe),
        .aBe_i    (aBe),
        .aAddr_i  (aAddr),
        .aWdata_i (aWdata),
        .aRdata_o (cpu_rdata),
        .bEn_i    (vid_en),
        .bAddr_i  (vid_addr),
        .bRdata_o (vid_rdata)
    );

    assign cpu_rvalid = cpuRvalid_q;
    assign vid_rvalid = vidRvalid_q;

endmodule

// File: tb/tb_hdmi_vram_fb.sv
// Directed self-checking bench for hdmi_vram_fb: CPU byte writes, video reads,
// fill wrap/stall/zero-length behaviour, reset mid-fill and a whole-memory fill.
module tb_hdmi_vram_fb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 13;
   localparam int NB     = DATA_W / 8;

   logic              clk;
   logic              rst_n;
   logic              cpu_req;
   logic              cpu_we;
   logic [NB-1:0]     cpu_be;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              vid_en;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_rvalid;
   logic [DATA_W-1:0] vid_rdata;
   logic              fill_start;
   logic [ADDR_W-1:0] fill_base;
   logic [ADDR_W:0]   fill_len;
   logic [DATA_W-1:0] fill_pattern;
   logic              fill_busy;
   logic              fill_done;

   int checkCount = 0;
   int errorCount = 0;

   hdmi_vram_fb #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_be       (cpu_be),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_ready    (cpu_ready),
      .cpu_rvalid   (cpu_rvalid),
      .cpu_rdata    (cpu_rdata),
      .vid_en       (vid_en),
      .vid_addr     (vid_addr),
      .vid_rvalid   (vid_rvalid),
      .vid_rdata    (vid_rdata),
      .fill_start   (fill_start),
      .fill_base    (fill_base),
      .fill_len     (fill_len),
      .fill_pattern (fill_pattern),
      .fill_busy    (fill_busy),
      .fill_done    (fill_done)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change #1 after the rising edge, outputs are sampled there too.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [NB-1:0] be,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
      cpu_req   = req;
      cpu_we    = we;
      cpu_be    = be;
      cpu_addr  = addr;
      cpu_wdata = wdata;
   endtask

   task automatic cpuWrite(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data, input logic [NB-1:0] be);
      applyStimulus(1'b1, 1'b1, be, addr, data);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic cpuRead(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expected, input string tag);
      applyStimulus(1'b1, 1'b0, '0, addr, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      checkOutput({tag, "_rvalid"}, {63'd0, cpu_rvalid}, 64'd1);
      checkOutput(tag, {32'd0, cpu_rdata}, {32'd0, expected});
   endtask

   task automatic startFill(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len, input logic [DATA_W-1:0] pattern);
      fill_start   = 1'b1;
      fill_base    = base;
      fill_len     = len;
      fill_pattern = pattern;
   endtask

   // Directed scenario sequence with hand-computed expectations.
   initial begin
      logic [15:0] acceptMask;
      logic [15:0] busyMask;
      logic [15:0] doneMask;
      int          vidValidCount;
      int          busyCount;
      int          doneCount;
      bit          finished;

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      vid_en       = 1'b0;
      vid_addr     = '0;
      fill_start   = 1'b0;
      fill_base    = '0;
      fill_len     = '0;
      fill_pattern = '0;

      #3;
      checkOutput("rst_fill_busy", {63'd0, fill_busy}, 64'd0);
      checkOutput("rst_fill_done", {63'd0, fill_done}, 64'd0);
      checkOutput("rst_cpu_rvalid", {63'd0, cpu_rvalid}, 64'd0);
      checkOutput("rst_vid_rvalid", {63'd0, vid_rvalid}, 64'd0);
      checkOutput("rst_cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
      checkOutput("rst_vid_rdata", {32'd0, vid_rdata}, 64'd0);
      checkOutput("rst_cpu_ready", {63'd0, cpu_ready}, 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Byte-enable merge: AABBCCDD then lanes 0 and 2 from 11223344.
      cpuWrite(13'd5, 32'hAABBCCDD, 4'b1111);
      cpuWrite(13'd5, 32'h11223344, 4'b0101);
      cpuRead(13'd5, 32'hAA22CC44, "be_merge");
      tick();
      checkOutput("rvalid_one_cycle", {63'd0, cpu_rvalid}, 64'd0);
      checkOutput("rdata_hold", {32'd0, cpu_rdata}, 64'hAA22CC44);
      cpuWrite(13'd5, 32'hFFFFFFFF, 4'b0000);
      cpuRead(13'd5, 32'hAA22CC44, "be_zero");

      // Back-to-back video reads, one word per cycle.
      cpuWrite(13'd6, 32'h66666666, 4'b1111);
      cpuWrite(13'd7, 32'h77777777, 4'b1111);
      vid_en = 1'b1;
      vid_addr = 13'd5;
      tick();
      checkOutput("vid_rvalid_0", {63'd0, vid_rvalid}, 64'd1);
      checkOutput("vid_rdata_5", {32'd0, vid_rdata}, 64'hAA22CC44);
      vid_addr = 13'd6;
      tick();
      checkOutput("vid_rdata_6", {32'd0, vid_rdata}, 64'h66666666);
      vid_addr = 13'd7;
      tick();
      checkOutput("vid_rdata_7", {32'd0, vid_rdata}, 64'h77777777);
      vid_en = 1'b0;
      tick();
      checkOutput("vid_rvalid_off", {63'd0, vid_rvalid}, 64'd0);

      // Wrapping fill with a same-cycle CPU write, a held CPU write and a video collision.
      cpuWrite(13'h1FFD, 32'h99999999, 4'b1111);
      cpuWrite(13'h1FFE, 32'h11111111, 4'b1111);
      cpuWrite(13'h1FFF, 32'h22222222, 4'b1111);
      cpuWrite(13'h0000, 32'h33333333, 4'b1111);
      cpuWrite(13'h0001, 32'h44444444, 4'b1111);
      cpuWrite(13'h0002, 32'h02020202, 4'b1111);
      startFill(13'h1FFE, 14'd4, 32'h5A5A5A5A);
      applyStimulus(1'b1, 1'b1, 4'b1111, 13'd2, 32'h0BADF00D);
      vid_en = 1'b1;
      vid_addr = 13'h1FFE;
      acceptMask = '0;
      busyMask = '0;
      doneMask = '0;
      vidValidCount = 0;
      for (int k = 1; k <= 8; k++) begin
         if (cpu_req && cpu_ready) acceptMask[k] = 1'b1;
         tick();
         if (k == 1) begin
            fill_start = 1'b0;
            cpu_addr   = 13'd3;
            cpu_wdata  = 32'h33CC33CC;
         end else if (acceptMask[k]) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0);
         end
         busyMask[k] = fill_busy;
         doneMask[k] = fill_done;
         if (vid_rvalid) vidValidCount++;
         if (k == 1) checkOutput("vid_pre_fill", {32'd0, vid_rdata}, 64'h11111111);
         if (k == 2) checkOutput("vid_collision_old", {32'd0, vid_rdata}, 64'h11111111);
         if (k == 3) checkOutput("vid_after_fill", {32'd0, vid_rdata}, 64'h5A5A5A5A);
      end
      vid_en = 1'b0;
      checkOutput("fill_accept_edges", {48'd0, acceptMask}, 64'h0082);
      checkOutput("fill_busy_cycles", {48'd0, busyMask}, 64'h003E);
      checkOutput("fill_done_cycle", {48'd0, doneMask}, 64'h0020);
      checkOutput("vid_no_stall", 64'(vidValidCount), 64'd8);
      cpuRead(13'h1FFD, 32'h99999999, "fill_below_base");
      cpuRead(13'h1FFE, 32'h5A5A5A5A, "fill_1FFE");
      cpuRead(13'h1FFF, 32'h5A5A5A5A, "fill_1FFF");
      cpuRead(13'h0000, 32'h5A5A5A5A, "fill_0000");
      cpuRead(13'h0001, 32'h5A5A5A5A, "fill_0001");
      cpuRead(13'h0002, 32'h0BADF00D, "same_cycle_cpu");
      cpuRead(13'h0003, 32'h33CC33CC, "held_cpu_write");

      // Zero-length fill: done next cycle, one stall cycle, no write.
      cpuWrite(13'h0010, 32'h10101010, 4'b1111);
      startFill(13'h0010, 14'd0, 32'hFFFFFFFF);
      tick();
      fill_start = 1'b0;
      checkOutput("len0_done", {63'd0, fill_done}, 64'd1);
      checkOutput("len0_stall", {63'd0, cpu_ready}, 64'd0);
      applyStimulus(1'b1, 1'b0, '0, 13'h0010, '0);
      tick();
      checkOutput("len0_done_pulse", {63'd0, fill_done}, 64'd0);
      checkOutput("len0_ready_back", {63'd0, cpu_ready}, 64'd1);
      checkOutput("len0_no_early_read", {63'd0, cpu_rvalid}, 64'd0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      checkOutput("len0_rvalid", {63'd0, cpu_rvalid}, 64'd1);
      checkOutput("len0_unchanged", {32'd0, cpu_rdata}, 64'h10101010);

      // Reset after 3 of 10 fill writes.
      for (int i = 0; i < 10; i++) begin
         cpuWrite(13'h0100 + 13'(i), 32'hA0000000 + 32'(i), 4'b1111);
      end
      vid_en = 1'b1;
      vid_addr = 13'h0100;
      startFill(13'h0100, 14'd10, 32'hC3C3C3C3);
      tick();
      fill_start = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {63'd0, fill_busy}, 64'd0);
      checkOutput("abort_done", {63'd0, fill_done}, 64'd0);
      checkOutput("abort_vid_rvalid", {63'd0, vid_rvalid}, 64'd0);
      checkOutput("abort_vid_rdata", {32'd0, vid_rdata}, 64'd0);
      checkOutput("abort_cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
      doneCount = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (fill_done) doneCount++;
      end
      rst_n = 1'b1;
      vid_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (fill_done) doneCount++;
      end
      checkOutput("abort_no_done", 64'(doneCount), 64'd0);
      cpuRead(13'h0100, 32'hC3C3C3C3, "abort_kept_0");
      cpuRead(13'h0102, 32'hC3C3C3C3, "abort_kept_2");
      cpuRead(13'h0103, 32'hA0000003, "abort_unwritten");
      startFill(13'h0200, 14'd1, 32'h77777777);
      tick();
      fill_start = 1'b0;
      checkOutput("refill_busy", {63'd0, fill_busy}, 64'd1);
      tick();
      checkOutput("refill_done", {63'd0, fill_done}, 64'd1);
      tick();
      checkOutput("refill_idle", {63'd0, fill_busy}, 64'd0);
      cpuRead(13'h0200, 32'h77777777, "refill_word");

      // Whole-memory fill starting mid-array; bounded wait.
      startFill(13'h00AB, 14'h2000, 32'h12345678);
      busyCount = 0;
      doneCount = 0;
      finished = 1'b0;
      for (int k = 1; k <= 9000 && !finished; k++) begin
         tick();
         fill_start = 1'b0;
         if (fill_busy) busyCount++;
         if (fill_done) doneCount++;
         if (!fill_busy) finished = 1'b1;
      end
      checkOutput("full_fill_finished", {63'd0, finished}, 64'd1);
      checkOutput("full_fill_busy", 64'(busyCount), 64'd8193);
      checkOutput("full_fill_done", 64'(doneCount), 64'd1);
      cpuRead(13'h00AA, 32'h12345678, "full_last");
      cpuRead(13'h1FFF, 32'h12345678, "full_top");
      cpuRead(13'h0000, 32'h12345678, "full_zero");

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
